// File: rtl/regarb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Contents:
//   ADDR_W_DFLT / DATA_W_DFLT  default register address / data widths
//   wb_req_t                   one writeback request {valid, addr, data}
//   rr_next(idx, n)            (idx + 1) mod n, without a divider
package regarb_pkg;

    localparam int ADDR_W_DFLT = 5;
    localparam int DATA_W_DFLT = 32;

    typedef struct packed {
        logic                   valid;
        logic [ADDR_W_DFLT-1:0] addr;
        logic [DATA_W_DFLT-1:0] data;
    } wb_req_t;

    // Increment-and-wrap; idx is always in 0..n-1, so one compare replaces a modulo.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regarb_pick2.sv
// Picks up to two writeback requests per cycle: aged first (lowest index), then round-robin.
// Latency: purely combinational, no state.
// Backpressure: none of its own; a same-address second candidate is simply not picked.
//
// Ports:
//   valid   [NREQ]          request valid bits
//   addr    [NREQ*ADDR_W]   destination register per request (slice i)
//   rr_ptr  [IDX_W]         index where the round-robin scan starts
//   aged    [NREQ]          requesters that must be considered ahead of the scan
//   a_vld/a_idx             first pick (write port 0)
//   b_vld/b_idx             second pick (write port 1), never the same address as A
module regarb_pick2
    import regarb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int IDX_W  = 2
) (
    input  logic [NREQ-1:0]        valid,
    input  logic [NREQ*ADDR_W-1:0] addr,
    input  logic [IDX_W-1:0]       rr_ptr,
    input  logic [NREQ-1:0]        aged,
    output logic                   a_vld,
    output logic [IDX_W-1:0]       a_idx,
    output logic                   b_vld,
    output logic [IDX_W-1:0]       b_idx
);

    localparam int NORD = 2 * NREQ;

    logic [ADDR_W-1:0] addr_arr [NREQ];
    logic [IDX_W-1:0]  ord      [NORD];
    logic              ord_ok   [NORD];
    logic [ADDR_W-1:0] a_addr;
    logic [IDX_W-1:0]  cand;
    int                pos;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g] = addr[g*ADDR_W +: ADDR_W];
    end

    always_comb begin
        a_vld  = 1'b0;
        a_idx  = '0;
        b_vld  = 1'b0;
        b_idx  = '0;
        a_addr = '0;
        cand   = '0;
        pos    = int'(rr_ptr);
        for (int p = 0; p < NORD; p++) begin
            ord[p]    = '0;
            ord_ok[p] = 1'b0;
        end

        // Candidate order: slots 0..NREQ-1 hold aged requesters by index,
        // slots NREQ.. hold the rest in round-robin order from rr_ptr.
        for (int i = 0; i < NREQ; i++) begin
            ord[i]    = IDX_W'(i);
            ord_ok[i] = valid[i] && aged[i];
        end
        for (int k = 0; k < NREQ; k++) begin
            cand           = IDX_W'(pos);
            ord[NREQ+k]    = cand;
            ord_ok[NREQ+k] = valid[cand] && !aged[cand];
            pos            = rr_next(pos, NREQ);
        end

        // First eligible wins port 0; the next one with a different address
        // wins port 1. A same-address candidate is passed over and stays pending.
        for (int p = 0; p < NORD; p++) begin
            if (ord_ok[p]) begin
                if (!a_vld) begin
                    a_vld  = 1'b1;
                    a_idx  = ord[p];
                    a_addr = addr_arr[ord[p]];
                end else if (!b_vld && (addr_arr[ord[p]] != a_addr)) begin
                    b_vld = 1'b1;
                    b_idx = ord[p];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the two register-file write ports among NREQ writeback requesters, round-robin fair.
// Latency: grant (req_ready) in cycle N, registered write/wa/wd on the ports in cycle N+1.
// Backpressure: valid/ready per requester; stall, rst or a same-address conflict hold requests pending.
//
// Optional feature macro: REGARB_AGE_EN -- per-requester wait counters saturating at
// MAX_WAIT; a requester at MAX_WAIT is considered ahead of the round-robin scan.
// Without it the arbiter is pure round-robin and MAX_WAIT is ignored.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   stall                  no grants while high
//   req_valid/addr/data    per-requester request (addr/data packed, slice i = requester i)
//   req_ready              combinational grant; transfer on valid && ready
//   wa0/wd0, wa1/wd1       registered write address/data for ports 0/1 (hold when unused)
//   write[1:0]             registered write enables, port 1 / port 0
//   gnt_cnt                registered number of grants made last cycle
module regfile_wb_arbiter
    import regarb_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int ADDR_W   = ADDR_W_DFLT,
    parameter int DATA_W   = DATA_W_DFLT,
    parameter int MAX_WAIT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]      wa0,
    output logic [ADDR_W-1:0]      wa1,
    output logic [DATA_W-1:0]      wd0,
    output logic [DATA_W-1:0]      wd1,
    output logic [1:0]             write,
    output logic [1:0]             gnt_cnt
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0]  rr_ptr;
    logic [NREQ-1:0]   aged;
    logic              a_vld, b_vld;
    logic [IDX_W-1:0]  a_idx, b_idx;
    logic              grant_en, a_gnt, b_gnt;
    logic [ADDR_W-1:0] addr_arr [NREQ];
    logic [DATA_W-1:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    regarb_pick2 #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_pick (
        .valid  (req_valid),
        .addr   (req_addr),
        .rr_ptr (rr_ptr),
        .aged   (aged),
        .a_vld  (a_vld),
        .a_idx  (a_idx),
        .b_vld  (b_vld),
        .b_idx  (b_idx)
    );

    // Reset masks grants combinationally so nothing is in flight into the
    // cycle after reset.
    assign grant_en = !rst && !stall;
    assign a_gnt    = grant_en && a_vld;
    assign b_gnt    = grant_en && b_vld;

    always_comb begin
        req_ready = '0;
        if (a_gnt) req_ready[a_idx] = 1'b1;
        if (b_gnt) req_ready[b_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write   <= '0;
            gnt_cnt <= '0;
            wa0     <= '0;
            wd0     <= '0;
            wa1     <= '0;
            wd1     <= '0;
            rr_ptr  <= '0;
        end else begin
            write   <= {b_gnt, a_gnt};
            gnt_cnt <= 2'(a_gnt) + 2'(b_gnt);
            if (a_gnt) begin
                wa0 <= addr_arr[a_idx];
                wd0 <= data_arr[a_idx];
            end
            if (b_gnt) begin
                wa1 <= addr_arr[b_idx];
                wd1 <= data_arr[b_idx];
            end
            // B is only ever granted alongside A, so B is the last index granted.
            if (b_gnt) begin
                rr_ptr <= IDX_W'(rr_next(int'(b_idx), NREQ));
            end else if (a_gnt) begin
                rr_ptr <= IDX_W'(rr_next(int'(a_idx), NREQ));
            end
        end
    end

`ifdef REGARB_AGE_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_cnt [NREQ];

    // Counts cycles spent valid but not granted (stall included); a drop or
    // a grant restarts the count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst || !req_valid[i] || req_ready[i]) begin
                wait_cnt[i] <= '0;
            end else if (wait_cnt[i] != CNT_W'(MAX_WAIT)) begin
                wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        aged = '0;
        for (int i = 0; i < NREQ; i++) begin
            aged[i] = (wait_cnt[i] == CNT_W'(MAX_WAIT));
        end
    end
`else
    logic [31:0] unused_max_wait;

    assign aged            = '0;
    assign unused_max_wait = MAX_WAIT;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table, hand sequences, randomized run vs. model.
// Latency: checks req_ready before each edge and the registered write ports 1 time unit after it.
// Backpressure: requesters hold pending requests until ready, with occasional legal drops.
module tb_regfile_wb_arbiter;
    import regarb_pkg::*;

    localparam int NREQ  = 3;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int MAX_W = 2;
    localparam int NV    = 13;

    logic                 clk;
    logic                 rst;
    logic                 stall;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [AW-1:0]        wa0, wa1;
    logic [DW-1:0]        wd0, wd1;
    logic [1:0]           write;
    logic [1:0]           gnt_cnt;

    wb_req_t rq [NREQ];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_rr = 0;
    int          m_wait [NREQ];
    logic [1:0]  m_write = '0;
    logic [1:0]  m_cnt   = '0;
    logic [AW-1:0] m_wa0 = '0, m_wa1 = '0;
    logic [DW-1:0] m_wd0 = '0, m_wd1 = '0;

    logic [NREQ-1:0] got_rdy;

    typedef struct {
        logic        stall;
        logic [2:0]  vld;
        logic [14:0] a;
        logic [95:0] d;
        logic [2:0]  e_rdy;
        logic [1:0]  e_wr;
        logic [4:0]  e_wa0;
        logic [31:0] e_wd0;
        logic [4:0]  e_wa1;
        logic [31:0] e_wd1;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t tbl [NV];

    regfile_wb_arbiter #(
        .NREQ     (NREQ),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MAX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wa0       (wa0),
        .wa1       (wa1),
        .wd0       (wd0),
        .wd1       (wd1),
        .write     (write),
        .gnt_cnt   (gnt_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = rq[i].valid;
            req_addr[i*AW +: AW]  = rq[i].addr;
            req_data[i*DW +: DW]  = rq[i].data;
        end
    end

    function automatic vec_t mk(input int st, input int vld, input int a0, input int a1,
                                input int a2, input int d0, input int d1, input int d2,
                                input int er, input int ew, input int wa0_e, input int wd0_e,
                                input int wa1_e, input int wd1_e, input int cnt);
        vec_t v;
        v.stall = 1'(st);
        v.vld   = 3'(vld);
        v.a     = {5'(a2), 5'(a1), 5'(a0)};
        v.d     = {32'(d2), 32'(d1), 32'(d0)};
        v.e_rdy = 3'(er);
        v.e_wr  = 2'(ew);
        v.e_wa0 = 5'(wa0_e);
        v.e_wd0 = 32'(wd0_e);
        v.e_wa1 = 5'(wa1_e);
        v.e_wd1 = 32'(wd1_e);
        v.e_cnt = 2'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Candidate list: aged requesters by index (aging build only), then the
    // remaining valid ones in circular order starting at the round-robin pointer.
    task automatic model_pick(output logic [NREQ-1:0] rdy, output int ga, output int gb);
        int order[$];
        bit seen [NREQ];
        rdy = '0;
        ga  = -1;
        gb  = -1;
        for (int i = 0; i < NREQ; i++) seen[i] = 1'b0;
        if (!(rst || stall)) begin
`ifdef REGARB_AGE_EN
            for (int i = 0; i < NREQ; i++) begin
                if (rq[i].valid && m_wait[i] >= MAX_W) begin
                    order.push_back(i);
                    seen[i] = 1'b1;
                end
            end
`endif
            for (int k = 0; k < NREQ; k++) begin
                int i = (m_rr + k) % NREQ;
                if (rq[i].valid && !seen[i]) order.push_back(i);
            end
            if (order.size() > 0) ga = order[0];
            for (int j = 1; j < order.size(); j++) begin
                if (gb < 0 && rq[order[j]].addr != rq[ga].addr) gb = order[j];
            end
            if (ga >= 0) rdy[ga] = 1'b1;
            if (gb >= 0) rdy[gb] = 1'b1;
        end
    endtask

    task automatic model_update(input logic [NREQ-1:0] rdy, input int ga, input int gb);
        if (rst) begin
            m_write = '0;
            m_cnt   = '0;
            m_wa0   = '0;
            m_wd0   = '0;
            m_wa1   = '0;
            m_wd1   = '0;
            m_rr    = 0;
            for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
        end else begin
            m_write = {logic'(gb >= 0), logic'(ga >= 0)};
            m_cnt   = 2'(int'(ga >= 0) + int'(gb >= 0));
            if (ga >= 0) begin
                m_wa0 = rq[ga].addr;
                m_wd0 = rq[ga].data;
            end
            if (gb >= 0) begin
                m_wa1 = rq[gb].addr;
                m_wd1 = rq[gb].data;
            end
            if (gb >= 0)      m_rr = (gb + 1) % NREQ;
            else if (ga >= 0) m_rr = (ga + 1) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!rq[i].valid || rdy[i]) m_wait[i] = 0;
                else if (m_wait[i] < MAX_W) m_wait[i] = m_wait[i] + 1;
            end
        end
    endtask

    // Inputs are already applied; checks ready before the edge, ports after it.
    task automatic do_cycle(input string tag);
        logic [NREQ-1:0] e_rdy;
        int ga, gb;
        #1;
        model_pick(e_rdy, ga, gb);
        got_rdy = req_ready;
        chk({tag, " ready"}, 64'(req_ready), 64'(e_rdy));
        @(posedge clk);
        model_update(e_rdy, ga, gb);
        #1;
        chk({tag, " write"},   64'(write),   64'(m_write));
        chk({tag, " gnt_cnt"}, 64'(gnt_cnt), 64'(m_cnt));
        chk({tag, " wa0"},     64'(wa0),     64'(m_wa0));
        chk({tag, " wd0"},     64'(wd0),     64'(m_wd0));
        chk({tag, " wa1"},     64'(wa1),     64'(m_wa1));
        chk({tag, " wd1"},     64'(wd1),     64'(m_wd1));
    endtask

    task automatic set_req(input int i, input logic v, input int a, input int d);
        rq[i].valid = v;
        rq[i].addr  = 5'(a);
        rq[i].data  = 32'(d);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) m_wait[i] = 0;

        // Sequential rows starting from rr_ptr = 0 right after reset.
        //           st  vld    a0 a1 a2  d0     d1     d2     rdy    wr    wa0 wd0    wa1 wd1    cnt
        tbl[0]  = mk(0, 'b011, 3, 7, 0, 'hA5,  'h5A,  0,     'b011, 'b11, 3, 'hA5,  7, 'h5A,  2);
        tbl[1]  = mk(0, 'b011, 5, 5, 0, 'h11,  'h22,  0,     'b001, 'b01, 5, 'h11,  7, 'h5A,  1);
        tbl[2]  = mk(0, 'b010, 5, 5, 0, 'h11,  'h22,  0,     'b010, 'b01, 5, 'h22,  7, 'h5A,  1);
        tbl[3]  = mk(0, 'b100, 0, 0, 9, 0,     0,     'h33,  'b100, 'b01, 9, 'h33,  7, 'h5A,  1);
        tbl[4]  = mk(0, 'b111, 1, 2, 3, 'h101, 'h102, 'h103, 'b011, 'b11, 1, 'h101, 2, 'h102, 2);
        tbl[5]  = mk(0, 'b111, 1, 2, 3, 'h201, 'h202, 'h103, 'b101, 'b11, 3, 'h103, 1, 'h201, 2);
        tbl[6]  = mk(0, 'b111, 1, 2, 3, 'h301, 'h202, 'h303, 'b110, 'b11, 2, 'h202, 3, 'h303, 2);
        tbl[7]  = mk(1, 'b100, 0, 0, 4, 0,     0,     'h44,  'b000, 'b00, 2, 'h202, 3, 'h303, 0);
        tbl[8]  = mk(1, 'b100, 0, 0, 4, 0,     0,     'h44,  'b000, 'b00, 2, 'h202, 3, 'h303, 0);
        tbl[9]  = mk(1, 'b100, 0, 0, 4, 0,     0,     'h44,  'b000, 'b00, 2, 'h202, 3, 'h303, 0);
        tbl[10] = mk(1, 'b100, 0, 0, 4, 0,     0,     'h44,  'b000, 'b00, 2, 'h202, 3, 'h303, 0);
        tbl[11] = mk(0, 'b100, 0, 0, 4, 0,     0,     'h44,  'b100, 'b01, 4, 'h44,  3, 'h303, 1);
        tbl[12] = mk(0, 'b000, 0, 0, 4, 0,     0,     'h44,  'b000, 'b00, 4, 'h44,  3, 'h303, 0);

        // Reset with every requester valid
        rst   = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 1, 'hC0 + i);
        do_cycle("reset0");
        chk("reset ready",   64'(got_rdy), 64'(0));
        chk("reset write",   64'(write),   64'(0));
        chk("reset wa0",     64'(wa0),     64'(0));
        chk("reset wd0",     64'(wd0),     64'(0));
        chk("reset gnt_cnt", 64'(gnt_cnt), 64'(0));
        do_cycle("reset1");
        rst = 1'b0;

        // Directed vector table
        for (int r = 0; r < NV; r++) begin
            stall = tbl[r].stall;
            for (int i = 0; i < NREQ; i++) begin
                rq[i].valid = tbl[r].vld[i];
                rq[i].addr  = tbl[r].a[i*AW +: AW];
                rq[i].data  = tbl[r].d[i*DW +: DW];
            end
            do_cycle($sformatf("vec%0d", r));
            chk($sformatf("vec%0d tbl ready", r), 64'(got_rdy), 64'(tbl[r].e_rdy));
            chk($sformatf("vec%0d tbl write", r), 64'(write),   64'(tbl[r].e_wr));
            chk($sformatf("vec%0d tbl wa0", r),   64'(wa0),     64'(tbl[r].e_wa0));
            chk($sformatf("vec%0d tbl wd0", r),   64'(wd0),     64'(tbl[r].e_wd0));
            chk($sformatf("vec%0d tbl wa1", r),   64'(wa1),     64'(tbl[r].e_wa1));
            chk($sformatf("vec%0d tbl wd1", r),   64'(wd1),     64'(tbl[r].e_wd1));
            chk($sformatf("vec%0d tbl cnt", r),   64'(gnt_cnt), 64'(tbl[r].e_cnt));
        end

        // req2 shares its address with req1 and keeps getting passed over
        stall = 1'b0;
        rst   = 1'b1;
        do_cycle("age rst");
        rst = 1'b0;
        set_req(0, 1'b1, 9, 'h900);
        set_req(1, 1'b0, 8, 'h800);
        set_req(2, 1'b0, 8, 'h802);
        do_cycle("age c0");
        chk("age c0 ready", 64'(got_rdy), 64'(3'b001));
        set_req(0, 1'b1, 9, 'h901);
        set_req(1, 1'b1, 8, 'h801);
        set_req(2, 1'b1, 8, 'h802);
        do_cycle("age c1");
        chk("age c1 ready", 64'(got_rdy), 64'(3'b011));
        set_req(0, 1'b1, 9, 'h902);
        set_req(1, 1'b1, 8, 'h803);
        do_cycle("age c2");
        chk("age c2 ready", 64'(got_rdy), 64'(3'b011));
        set_req(0, 1'b1, 9, 'h903);
        set_req(1, 1'b1, 8, 'h804);
        do_cycle("age c3");
`ifdef REGARB_AGE_EN
        chk("age c3 ready", 64'(got_rdy), 64'(3'b101));
        chk("age c3 wd0",   64'(wd0),     64'('h802));
`else
        chk("age c3 ready", 64'(got_rdy), 64'(3'b011));
        chk("age c3 wd0",   64'(wd0),     64'('h804));
`endif
        chk("age c3 wa0", 64'(wa0), 64'(8));
        chk("age c3 wd1", 64'(wd1), 64'('h903));

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rq[i].valid || got_rdy[i]) begin
                    rq[i].valid = ($urandom_range(3) != 0);
                    rq[i].addr  = 5'($urandom_range(3));
                    rq[i].data  = $urandom;
                end else if ($urandom_range(9) == 0) begin
                    rq[i].valid = 1'b0;
                end
            end
            stall = ($urandom_range(7) == 0);
            rst   = ($urandom_range(49) == 0);
            do_cycle($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
